// File: rtl/lane_update_scheduler.sv
// lane_update_scheduler
// Once per frame (vsync falling edge) walks lanes 0..LANES-1, advances each
// lane's frame counter and, when a lane's period expires, issues a single
// req/ack update request for that lane. Requests are abandoned after ACK_TMO
// cycles without an acknowledge.
// Optional build macro: LANE_SCHED_BLANK_GUARD_EN -- when defined, upd_req is
// only presented while valid=0 (vertical/horizontal blanking).
module lane_update_scheduler #(
  parameter int LANES   = 12,
  parameter int SPD_W   = 4,
  parameter int ACK_TMO = 1023
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   valid,
  input  logic                   pause,
  input  logic [LANES*SPD_W-1:0] lane_speed,
  output logic                   upd_req,
  output logic [3:0]             upd_lane,
  input  logic                   upd_ack,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic                   overrun,
  output logic                   tmo_err
);

  localparam int         WAIT_W   = $clog2(ACK_TMO + 1);
  localparam logic [3:0] LAST_IDX = 4'(LANES - 1);

  typedef enum logic [1:0] {IDLE, EVAL, REQ, DONE} state_t;

  state_t              state;
  logic                vs_q;
  logic [SPD_W-1:0]    cnt [LANES];
  logic [3:0]          idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                req_q;

  logic                strobe;
  logic [SPD_W-1:0]    spd;
  logic [SPD_W-1:0]    cur_cnt;
  logic [SPD_W:0]      cnt_inc;
  logic                frozen;
  logic                fire;
  logic                ack_seen;
  logic                hold;

  assign strobe = vs_q & ~vsync;

`ifdef LANE_SCHED_BLANK_GUARD_EN
  // Request is only visible during blanking; the wait counter and any ack
  // are parked while the display is active.
  assign ack_seen = upd_ack & ~valid;
  assign hold     = valid;
  assign upd_req  = req_q & ~valid;
`else
  logic unused_valid;
  assign unused_valid = valid;
  assign ack_seen     = upd_ack;
  assign hold         = 1'b0;
  assign upd_req      = req_q;
`endif

  // Select the period field and counter of the lane currently being scanned.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    spd     = '0;
    cur_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == 4'(i)) begin
        spd     = lane_speed[i*SPD_W +: SPD_W];
        cur_cnt = cnt[i];
      end
    end
  end

  assign cnt_inc = {1'b0, cur_cnt} + (SPD_W+1)'(1);
  assign frozen  = (spd == '0) || pause;
  assign fire    = !frozen && (cnt_inc >= {1'b0, spd});

  // Frame strobe bookkeeping plus the scan/request state machine.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      vs_q      <= 1'b1;
      idx       <= '0;
      wait_cnt  <= '0;
      req_q     <= 1'b0;
      upd_lane  <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      tmo_err   <= 1'b0;
      // NOTE: the lane counters are a small register array, not RAM, and must
      // start from zero so the first period after reset is a full one.
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the value from before this clock edge.
      vs_q <= vsync;
      if (strobe) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (busy) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (strobe && !busy) begin
            state <= EVAL;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end

        EVAL: begin
          if (fire) begin
            cnt[idx] <= '0;
            state    <= REQ;
            req_q    <= 1'b1;
            upd_lane <= idx;
            wait_cnt <= '0;
          end else begin
            if (!frozen) cnt[idx] <= cnt_inc[SPD_W-1:0];
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + 4'd1;
          end
        end

        REQ: begin
          if (!hold) begin
            if (ack_seen || (wait_cnt == WAIT_W'(ACK_TMO - 1))) begin
              req_q <= 1'b0;
              if (!ack_seen) tmo_err <= 1'b1;
              if (idx == LAST_IDX) begin
                state <= DONE;
              end else begin
                state <= EVAL;
                idx   <= idx + 4'd1;
              end
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
